// File: rtl/shiftadd_pkg.sv
// Shared types and constants for the shift-add multiplier scheduler.
package shiftadd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int NUM_REQ = 2;

    // Bit counter must hold values 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shiftadd_arb.sv
// Two-requester arbiter: one-hot grant, fixed priority to requester 0 by default,
// round-robin when SHIFTADD_RR_ARB_EN is defined.
module shiftadd_arb
    import shiftadd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_gnt
);

`ifdef SHIFTADD_RR_ARB_EN
    // Id of the requester currently holding highest priority.
    logic r_prio;

    always_comb begin
        o_gnt = '0;
        if (!r_prio) begin
            if (i_req[0])      o_gnt = 2'b01;
            else if (i_req[1]) o_gnt = 2'b10;
        end else begin
            if (i_req[1])      o_gnt = 2'b10;
            else if (i_req[0]) o_gnt = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_prio <= 1'b0;
        else if (i_accept) r_prio <= ~o_gnt[1];
    end
`else
    always_comb begin
        o_gnt = '0;
        if (i_req[0])      o_gnt = 2'b01;
        else if (i_req[1]) o_gnt = 2'b10;
    end

    logic w_unused;
    assign w_unused = ^{clk, rst, i_accept};
`endif

endmodule

// File: rtl/shiftadd_mult_sched.sv
// Controller for an external shift-add multiplier datapath, shared by two requesters.
// Arbitration policy is selected inside shiftadd_arb (SHIFTADD_RR_ARB_EN).
module shiftadd_mult_sched
    import shiftadd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*WIDTH-1:0]   req_mplier,
    input  logic [2*WIDTH-1:0]   req_mcand,
    output logic                 dp_load,
    output logic                 dp_shift,
    output logic                 dp_add,
    output logic [WIDTH-1:0]     dp_multiplier,
    output logic [WIDTH-1:0]     dp_multiplicand,
    input  logic                 dp_lsb,
    input  logic [2*WIDTH:0]     dp_product,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    input  logic                 rsp_ready
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_mcand;
    logic                 r_id;
    logic                 r_rsp_valid;
    logic [2*WIDTH-1:0]   r_rsp_product;

    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_accept;
    logic                 w_gnt_id;
    logic                 w_last;
    logic                 w_unused_guard;

    shiftadd_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // Grants are only visible in IDLE and are forced off while reset is held.
    assign req_ready = (r_state == S_IDLE && !rst) ? w_gnt : '0;
    assign w_accept  = |(req_valid & req_ready);
    assign w_gnt_id  = w_gnt[1];
    assign w_last    = (r_cnt == LAST_BIT);

    assign dp_load  = (r_state == S_LOAD);
    assign dp_add   = (r_state == S_EVAL) && dp_lsb;
    assign dp_shift = (r_state == S_SHIFT) || ((r_state == S_EVAL) && !dp_lsb);

    assign dp_multiplier   = r_mplier;
    assign dp_multiplicand = r_mcand;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_id          = r_id;
    assign rsp_product     = r_rsp_product;

    assign w_unused_guard = dp_product[2*WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mplier      <= '0;
            r_mcand       <= '0;
            r_id          <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mplier <= req_mplier[int'(w_gnt_id)*WIDTH +: WIDTH];
                        r_mcand  <= req_mcand[int'(w_gnt_id)*WIDTH +: WIDTH];
                        r_id     <= w_gnt_id;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (dp_lsb) begin
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= w_last ? S_DONE : S_EVAL;
                    end
                end
                S_SHIFT: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? S_DONE : S_EVAL;
                end
                S_DONE: begin
                    // The final shift lands on the edge that enters DONE, so the
                    // product is captured one cycle later before raising valid.
                    if (!r_rsp_valid) begin
                        r_rsp_product <= dp_product[2*WIDTH-1:0];
                        r_rsp_valid   <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftadd_mult_sched.sv
// Scoreboard bench for shiftadd_mult_sched with a behavioural shift-add datapath model.
module tb_shiftadd_mult_sched;

    localparam int W = 4;

    typedef struct {
        int id;
        int a;
        int prod;
        int acc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*W-1:0]   req_mplier;
    logic [2*W-1:0]   req_mcand;
    logic             dp_load, dp_shift, dp_add;
    logic [W-1:0]     dp_multiplier, dp_multiplicand;
    logic             dp_lsb;
    logic [2*W:0]     dp_product;
    logic             rsp_valid;
    logic             rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             rsp_ready;

    logic             rv [2];
    logic [W-1:0]     a_op [2];
    logic [W-1:0]     b_op [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_load, n_add, n_shift;
    bit prev_v;
    exp_t sb[$];
    int   gnt_log[$];

    assign req_valid  = {rv[1], rv[0]};
    assign req_mplier = {a_op[1], a_op[0]};
    assign req_mcand  = {b_op[1], b_op[0]};
    assign dp_lsb     = dp_product[0];

    shiftadd_mult_sched #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_mplier      (req_mplier),
        .req_mcand       (req_mcand),
        .dp_load         (dp_load),
        .dp_shift        (dp_shift),
        .dp_add          (dp_add),
        .dp_multiplier   (dp_multiplier),
        .dp_multiplicand (dp_multiplicand),
        .dp_lsb          (dp_lsb),
        .dp_product      (dp_product),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_product     (rsp_product),
        .rsp_ready       (rsp_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Datapath: load {0,multiplier}, add multiplicand into the upper half, shift right.
    always @(posedge clk or posedge rst) begin
        if (rst)           dp_product <= '0;
        else if (dp_load)  dp_product <= {{(W+1){1'b0}}, dp_multiplier};
        else if (dp_add)   dp_product[2*W:W] <= dp_product[2*W:W] + {1'b0, dp_multiplicand};
        else if (dp_shift) dp_product <= dp_product >> 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: records accepts into the scoreboard and checks responses.
    initial begin
        exp_t e;
        prev_v = 1'b0;
        n_load = 0; n_add = 0; n_shift = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_v = 1'b0;
                continue;
            end
            check("strobe_exclusive", 64'($countones({dp_load, dp_shift, dp_add}) <= 1), 1);
            n_load  += int'(dp_load);
            n_add   += int'(dp_add);
            n_shift += int'(dp_shift);
            if (rsp_valid) begin
                check("no_grant_in_done", req_ready, 0);
                if (sb.size() == 0) begin
                    check("rsp_without_request", rsp_valid, 0);
                end else begin
                    if (!prev_v) begin
                        check("latency", cyc - sb[0].acc, 2 + W + $countones(sb[0].a));
                        check("load_count", n_load, 1);
                        check("add_count", n_add, $countones(sb[0].a));
                        check("shift_count", n_shift, W);
                    end
                    if (rsp_ready) begin
                        check("rsp_product", rsp_product, sb[0].prod);
                        check("rsp_id", rsp_id, sb[0].id);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = rsp_valid;
            if ((req_valid & req_ready) != 2'b00) begin
                e.id   = int'(req_ready[1]);
                e.a    = int'(a_op[e.id]);
                e.prod = int'(a_op[e.id]) * int'(b_op[e.id]);
                e.acc  = cyc + 1;
                sb.push_back(e);
                gnt_log.push_back(e.id);
                n_load = 0; n_add = 0; n_shift = 0;
            end
        end
    end

    // Present one operation and wait for its grant; keep=1 leaves valid high for the next one.
    task automatic do_op(input int id, input int a, input int b, input bit keep);
        int w;
        a_op[id] = W'(a);
        b_op[id] = W'(b);
        rv[id]   = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (req_ready[id]) break;
            w++;
            if (w > 500) begin
                check("grant_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) rv[id] = 1'b0;
    endtask

    task automatic drive_req(input int id, input int n);
        for (int k = 0; k < n; k++)
            do_op(id, $urandom_range(0, 2**W-1), $urandom_range(0, 2**W-1), k < n-1);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sb.size() != 0 || rsp_valid) begin
            @(negedge clk);
            w++;
            if (w > 1000) begin
                check("idle_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ids[4];
        int steps;
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; a_op[i] = '0; b_op[i] = '0;
        end
`ifdef SHIFTADD_RR_ARB_EN
        exp_ids = '{0, 1, 0, 1};
`else
        exp_ids = '{0, 0, 0, 0};
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_strobes", {dp_load, dp_shift, dp_add}, 0);
        check("rst_dp_multiplier", dp_multiplier, 0);
        check("rst_dp_multiplicand", dp_multiplicand, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_product", rsp_product, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Both requesters held valid
        gnt_log.delete();
        fork
            drive_req(0, 4);
            drive_req(1, 2);
        join
        wait_idle();
        check("arb_log_size", 64'(gnt_log.size() >= 4), 1);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++)
            check("arb_order", gnt_log[k], exp_ids[k]);

        do_op(0, 13, 11, 0); wait_idle();
        do_op(0, 0, 15, 0);  wait_idle();
        do_op(0, 15, 15, 0); wait_idle();
        do_op(1, 1, 15, 0);  wait_idle();
        do_op(0, 8, 2, 0);   wait_idle();

        // Response backpressure with another request pending
        rsp_ready = 1'b0;
        do_op(0, 9, 7, 0);
        steps = 0;
        while (!rsp_valid && steps < 100) begin
            @(negedge clk);
            steps++;
        end
        #1;
        a_op[1] = 4'd3; b_op[1] = 4'd5; rv[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_product", rsp_product, 9 * 7);
            check("hold_no_grant", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        do_op(1, 3, 5, 0);
        wait_idle();

        // Randomised traffic with random response backpressure
        fork
            drive_req(0, 6);
            drive_req(1, 6);
            repeat (300) begin
                @(posedge clk);
                #1 rsp_ready = 1'($urandom_range(0, 1));
            end
        join
        rsp_ready = 1'b1;
        wait_idle();

        // Reset during the third EVAL/SHIFT step
        do_op(0, $urandom_range(0, 15), $urandom_range(1, 15), 0);
        steps = 0;
        for (int k = 0; k < 50 && steps < 3; k++) begin
            @(negedge clk);
            if (dp_add || dp_shift) steps++;
        end
        check("reached_step3", steps, 3);
        #2 rst = 1'b1;
        #1;
        check("abort_strobes", {dp_load, dp_shift, dp_add}, 0);
        check("abort_dp_operands", {dp_multiplier, dp_multiplicand}, 0);
        check("abort_rsp", {rsp_valid, rsp_id, rsp_product}, 0);
        check("abort_req_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        steps = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) steps++;
        end
        check("no_rsp_after_abort", steps, 0);
        @(posedge clk);
        #1;
        a_op[0] = 4'd11; b_op[0] = 4'd6; rv[0] = 1'b1;
        @(negedge clk);
        check("first_grant_after_rst", req_ready, 2'b01);
        @(posedge clk);
        #1 rv[0] = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shiftadd_mult_sched.md
SHIFTADD_MULT_SCHED -- requirements
Module: shiftadd_mult_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (min 2).
REQ-002 The block SHALL have ports clk (input, 1, clock) and rst (input, 1, reset: asynchronous, active-high).
REQ-003 The block SHALL have port req_valid (input, 2): per-requester operation request.
REQ-004 The block SHALL have port req_ready (output, 2): per-requester grant/accept, one-hot or zero.
REQ-005 The block SHALL have port req_mplier (input, 2*WIDTH): multiplier of requester i at bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port req_mcand (input, 2*WIDTH): multiplicand of requester i, same packing.
REQ-007 The block SHALL have ports dp_load, dp_shift and dp_add (each output, 1): datapath strobes, at most one high per cycle.
REQ-008 The block SHALL have ports dp_multiplier and dp_multiplicand (each output, WIDTH): registered operands of the accepted request.
REQ-009 The block SHALL have port dp_lsb (input, 1): product LSB from the datapath.
REQ-010 The block SHALL have port dp_product (input, 2*WIDTH+1): product register of the datapath.
REQ-011 The block SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_product (output, 2*WIDTH) and rsp_ready (input, 1): result channel.

Function
REQ-012 The block SHALL accept a request i only when req_valid[i] && req_ready[i], and SHALL raise req_ready only in IDLE, one bit at most.
REQ-013 On acceptance, the block SHALL register the operands to dp_multiplier/dp_multiplicand, store the winner id, and go to LOAD.
REQ-014 The FSM SHALL have states IDLE, LOAD, EVAL, SHIFT and DONE, encoded as a package enum.
REQ-015 LOAD SHALL assert dp_load for exactly one cycle, clear the bit counter and go to EVAL.
REQ-016 EVAL SHALL assert dp_add and go to SHIFT when dp_lsb=1; when dp_lsb=0 it SHALL assert dp_shift and count one bit.
REQ-017 SHIFT SHALL assert dp_shift and count one bit.
REQ-018 After a counted bit, the FSM SHALL go to DONE when the count reaches WIDTH, else back to EVAL.
REQ-019 Latency from acceptance to rsp_valid SHALL be 2 + WIDTH + popcount(multiplier) cycles.
REQ-020 DONE SHALL hold rsp_valid=1 with rsp_product=dp_product[2*WIDTH-1:0] captured in a register and rsp_id stable, until rsp_ready=1; it SHALL then go to IDLE.
REQ-021 The block SHALL NOT issue a new grant in the cycle in which the response handshake completes.
REQ-022 A requester SHALL keep req_valid and its operands stable until granted; the block SHALL NOT drop a pending request.
REQ-023 A multiplier of 0 SHALL take WIDTH shift-only steps; an all-ones multiplier SHALL take 2*WIDTH steps.
REQ-024 dp_product[2*WIDTH] is the carry guard; the block SHALL ignore it for the result.

Reset
REQ-025 On rst, asynchronously, the block SHALL go to IDLE and SHALL drive req_ready=0, all dp_* strobes=0, dp_multiplier=0, dp_multiplicand=0, rsp_valid=0, rsp_id=0 and rsp_product=0; it SHALL also clear the counter and the priority pointer.
REQ-026 rst asserted mid-operation SHALL abort the operation; no response SHALL be produced for the aborted request.
REQ-027 After rst is released, the first grant SHALL be possible on the first clk edge at which req_valid is nonzero.

Configuration
REQ-028 With SHIFTADD_RR_ARB_EN defined, arbitration SHALL be round-robin: the last granted id SHALL get the lowest priority on the next grant.
REQ-029 Without SHIFTADD_RR_ARB_EN, requester 0 SHALL always win a simultaneous request, and no priority pointer state SHALL exist.

Structure
REQ-030 Package shiftadd_pkg SHALL hold the FSM state enum, the requester count constant (2) and the counter width function (clog2(WIDTH+1)).
REQ-031 Arbitration SHALL be a sub-module shiftadd_arb (request vector in, one-hot grant out, pointer update on accept), with the RR macro local to it.
REQ-032 The block SHALL NOT instantiate the datapath; the bench SHALL connect a datapath model whose load sets product={0,multiplier}.

Verification
REQ-033 The bench SHALL drive WIDTH=4, req 0 with a=13, b=11 -> rsp_product=143, rsp_id=0, latency 2+4+3=9 cycles.
REQ-034 The bench SHALL drive a=0, b=15 -> 4 consecutive dp_shift cycles with no dp_add, then rsp_product=0.
REQ-035 The bench SHALL drive a=15, b=15 -> alternating add/shift for 8 cycles, then rsp_product=225.
REQ-036 The bench SHALL hold both requesters valid for 4 operations -> RR: ids 0,1,0,1; without the macro: 0,0,0,0.
REQ-037 The bench SHALL hold rsp_ready low for 5 cycles in DONE -> rsp_valid and rsp_product stay stable, and no req_ready is raised.
REQ-038 The bench SHALL assert rst during the 3rd EVAL/SHIFT step -> all outputs are 0 immediately, no rsp_valid appears, and the next request completes correctly.
